// File: rtl/logic_op_pkg.sv
// logic_op_pkg: op_e opcode enum, fill_e buffer occupancy states, apply_op(a,b,op) per-bit AND/OR/XOR/NAND helper
package logic_op_pkg;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} op_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} fill_e;
  function automatic logic apply_op(input logic a, input logic b, input op_e op);
    return op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : ~(a & b);
  endfunction
endpackage

// File: rtl/logic_op_fifo2.sv
// logic_op_fifo2: 2-entry valid/ready buffer; ports clk, rst_n (async low), in_valid/in_ready/in_data (in_ready registered from next fill), out_valid/out_ready/out_data (head entry)
module logic_op_fifo2
  import logic_op_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  logic [DW-1:0] mem [2];
  logic          rd_ptr, wr_ptr, push, pop;
  fill_e         fill, fill_nx;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = fill != EMPTY;
  assign out_data  = mem[rd_ptr];
  always_comb begin
    fill_nx = fill;
    fill_nx = push && !pop ? (fill == EMPTY ? ONE : FULL) :
              pop && !push ? (fill == FULL ? ONE : EMPTY) : fill;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fill     <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fill     <= fill_nx;
      in_ready <= fill_nx != FULL;
    end
  end
endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: registered bitwise AND/OR/XOR/NAND unit; ports clk, rst_n (async low), in_valid/in_ready/in_a/in_b/in_op, out_valid/out_ready/out_y/out_zero, txn_count (pop counter, only with LOGIC_OP_CNT_EN)
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero
`ifdef LOGIC_OP_CNT_EN
  ,
  output logic [CNT_W-1:0] txn_count
`endif
);
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   out_data;
  for (genvar i = 0; i < WIDTH; i++) begin : g_op
    assign y[i] = apply_op(in_a[i], in_b[i], op_e'(in_op));
  end
  logic_op_fifo2 #(.DW(WIDTH + 1)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({y, ~|y}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );
  assign out_y    = out_data[WIDTH:1];
  assign out_zero = out_data[0];
`ifdef LOGIC_OP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txn_count <= '0;
    else if (out_valid && out_ready) txn_count <= txn_count + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: table vectors, directed stall/reset sequences and random traffic against a queue model of logic_op_pipe
module tb_logic_op_pipe;
  localparam int W = 4;
`ifdef LOGIC_OP_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_zero;
  logic [W-1:0] in_a = '0, in_b = '0, out_y;
  logic [1:0] in_op = '0;
`ifdef LOGIC_OP_CNT_EN
  logic [CW-1:0] txn_count;
`endif
  always #5 clk = ~clk;
  logic_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_zero (out_zero)
`ifdef LOGIC_OP_CNT_EN
    ,
    .txn_count(txn_count)
`endif
  );
  int n_chk = 0, n_fail = 0;
  logic [W:0] q[$];
  int unsigned m_cnt = 0;
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    logic [W-1:0] y;
    case (op)
      2'd0: y = a & b;
      2'd1: y = a | b;
      2'd2: y = a ^ b;
      default: y = ~(a & b);
    endcase
    return {y, y == '0};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_y", 64'(out_y), 64'(q[0][W:1]));
      chk("out_zero", 64'(out_zero), 64'(q[0][0]));
    end
`ifdef LOGIC_OP_CNT_EN
    chk("txn_count", 64'(txn_count), 64'(m_cnt));
`endif
  endtask
  task automatic cyc(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input logic ordy);
    logic push, pop;
    in_valid = iv; in_a = a; in_b = b; in_op = op; out_ready = ordy;
    @(posedge clk);
    push = iv && q.size() < 2;
    pop = q.size() > 0 && ordy;
    if (pop) begin
      void'(q.pop_front());
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (push) q.push_back(ref_op(a, b, op));
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    q.delete();
    m_cnt = 0;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_y", 64'(out_y), 64'd0);
    chk("rst out_zero", 64'(out_zero), 64'd0);
`ifdef LOGIC_OP_CNT_EN
    chk("rst txn_count", 64'(txn_count), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1;
  endtask
  typedef struct {
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic [W-1:0] y;
    logic         z;
  } vec_t;
  vec_t vt[7];
  initial begin
    vt[0] = '{4'b0100, 4'b1100, 2'd0, 4'b0100, 1'b0};
    vt[1] = '{4'b1010, 4'b0101, 2'd0, 4'b0000, 1'b1};
    vt[2] = '{4'b1010, 4'b0101, 2'd1, 4'b1111, 1'b0};
    vt[3] = '{4'b1010, 4'b0101, 2'd2, 4'b1111, 1'b0};
    vt[4] = '{4'b1010, 4'b0101, 2'd3, 4'b1111, 1'b0};
    vt[5] = '{4'b1111, 4'b1111, 2'd3, 4'b0000, 1'b1};
    vt[6] = '{4'b1100, 4'b1010, 2'd2, 4'b0110, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1, vt[i].a, vt[i].b, vt[i].op, 1);
      chk("vec valid", 64'(out_valid), 64'd1);
      chk("vec y", 64'(out_y), 64'(vt[i].y));
      chk("vec zero", 64'(out_zero), 64'(vt[i].z));
    end
    cyc(0, '0, '0, 2'd0, 1);
    // three beats into a stalled consumer: third must wait, order preserved
    cyc(1, 4'b0011, 4'b0101, 2'd0, 0);
    cyc(1, 4'b0011, 4'b0101, 2'd1, 0);
    chk("stall in_ready", 64'(in_ready), 64'd0);
    cyc(1, 4'b0011, 4'b0101, 2'd2, 0);
    chk("stall head", 64'(out_y), 64'b0001);
    cyc(1, 4'b0011, 4'b0101, 2'd2, 1);
    chk("drain 2nd", 64'(out_y), 64'b0111);
    cyc(1, 4'b0011, 4'b0101, 2'd2, 1);
    chk("drain 3rd", 64'(out_y), 64'b0110);
    cyc(0, '0, '0, 2'd0, 1);
    chk("drained", 64'(out_valid), 64'd0);
    // full buffer then continuous push/pop
    cyc(1, 4'h1, 4'h2, 2'd1, 0);
    cyc(1, 4'h3, 4'h4, 2'd1, 0);
    for (int i = 0; i < 8; i++) cyc(1, W'(i), W'(i * 3), 2'(i), 1);
    cyc(0, '0, '0, 2'd0, 1);
    cyc(0, '0, '0, 2'd0, 1);
    // reset with two results buffered
    cyc(1, 4'h5, 4'h6, 2'd2, 0);
    cyc(1, 4'h7, 4'h8, 2'd1, 0);
    in_valid = 1;
    do_reset();
    cyc(0, '0, '0, 2'd0, 1);
    chk("post-reset empty", 64'(out_valid), 64'd0);
`ifdef LOGIC_OP_CNT_EN
    begin
      logic [CW-1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      cyc(1, 4'h1, 4'h1, 2'd0, 1);
      for (int i = 0; i < 5; i++) begin
        cyc(i < 4, 4'h1, 4'h1, 2'd0, 1);
        chk("txn seq", 64'(txn_count), 64'(exp_cnt[i]));
      end
    end
`endif
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
